// File: rtl/cnn_accel_pkg.sv
// Shared CNN accelerator constants and the requantize (round/saturate) helper.
package cnn_accel_pkg;

  localparam int CNN_WI    = 16;
  localparam int CNN_WO    = 8;
  localparam int CNN_SHIFT = 4;

  // 64-bit working width leaves headroom for the rounding add on any WI < 63.
  function automatic logic [31:0] requant(input logic signed [63:0] m,
                                          input int                 shift,
                                          input int                 wo,
                                          input logic               rnd);
    logic signed [63:0] t;
    logic signed [63:0] maxv;
    t = m;
    if (rnd && shift > 0) t = t + (64'sd1 <<< (shift - 1));
    t = t >>> shift;
    maxv = (64'sd1 <<< wo) - 64'sd1;
    if (t < 64'sd0) t = 64'sd0;
    else if (t > maxv) t = maxv;
    return t[31:0];
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Single-port line buffer for the pooling row pairs: synchronous write, combinational read.
module pool_linebuf #(
  parameter int DEPTH = 64,
  parameter int W     = 16,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 max-pool + requantize on a raster sample stream; latency 1, no backpressure.
// Optional macro MAXPOOL_ROUND_EN selects round-half-up instead of truncation.
module maxpool2x2_stream
  import cnn_accel_pkg::*;
#(
  parameter int WI     = CNN_WI,
  parameter int WO     = CNN_WO,
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int SHIFT  = CNN_SHIFT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WI-1:0] din,
  input  logic          vld_in,
  output logic [WO-1:0] dout,
  output logic          vld_out,
  output logic          frame_done
);

`ifdef MAXPOOL_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);
  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic signed [WI-1:0] h0;
  logic signed [WI-1:0] hmax;
  logic signed [WI-1:0] m;
  logic [WI-1:0]        lb_rdata;
  logic [AW-1:0]        lb_addr;
  logic                 lb_we;
  logic                 col_last;
  logic                 row_last;
  logic [31:0]          rq;
  logic                 unused_rq_hi;

  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  assign lb_addr  = AW'(col >> 1);
  assign lb_we    = vld_in && !rst && col[0] && !row[0];

  pool_linebuf #(
    .DEPTH(DEPTH),
    .W    (WI),
    .AW   (AW)
  ) u_linebuf (
    .clk  (clk),
    .we   (lb_we),
    .addr (lb_addr),
    .wdata(hmax),
    .rdata(lb_rdata)
  );

  always_comb begin
    hmax = ($signed(din) > h0) ? $signed(din) : h0;
    m    = ($signed(lb_rdata) > hmax) ? $signed(lb_rdata) : hmax;
    rq   = requant({{(64 - WI){m[WI-1]}}, m}, SHIFT, WO, ROUND_EN);
  end

  assign unused_rq_hi = ^rq[31:WO];

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      h0         <= '0;
      dout       <= '0;
      vld_out    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vld_out    <= 1'b0;
      frame_done <= 1'b0;
      if (vld_in) begin
        if (!col[0]) h0 <= $signed(din);
        // Bottom-right sample of each 2x2 window completes a pooled pixel.
        if (col[0] && row[0]) begin
          dout       <= rq[WO-1:0];
          vld_out    <= 1'b1;
          frame_done <= col_last && row_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream on a 4x4 frame with SHIFT=4.
module tb_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        vld_in = 1'b0;
  logic [7:0]  dout;
  logic        vld_out;
  logic        frame_done;

  typedef struct {
    logic [7:0] d;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  maxpool2x2_stream #(
    .WI(16), .WO(8), .WIDTH(4), .HEIGHT(4), .SHIFT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .vld_in    (vld_in),
    .dout      (dout),
    .vld_out   (vld_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (vld_out === 1'b1) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: dout=%0d frame_done=%0b, no output expected", dout, frame_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout !== e.d || frame_done !== e.fd) begin
          errors++;
          $display("FAIL output: dout=%0d frame_done=%0b, expected dout=%0d frame_done=%0b",
                   dout, frame_done, e.d, e.fd);
        end
      end
    end else if (!rst) begin
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_alone: frame_done=%0b with vld_out=%0b, expected 0", frame_done, vld_out);
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic fd);
    exp_t e;
    e.d  = d;
    e.fd = fd;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    push(a, 1'b0);
    push(b, 1'b0);
    push(c, 1'b0);
    push(d, 1'b1);
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    din    = d;
    vld_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    din    = 16'hDEAD;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_ramp(input int gap);
    for (int k = 0; k < 16; k++) send(16'(16 * k), gap);
  endtask

  task automatic send_const(input logic [15:0] v);
    for (int k = 0; k < 16; k++) send(v, 0);
  endtask

  task automatic drain();
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d outputs, expected %0d", name, got, want);
    end
  endtask

  initial begin
    int base;
    logic [7:0] rnd_exp;
    @(posedge clk); #1;

    // Reset held with vld_in asserted: all outputs stay zero.
    rst    = 1'b1;
    vld_in = 1'b1;
    din    = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dout !== 8'd0 || vld_out !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: dout=%0d vld_out=%0b frame_done=%0b, expected all 0",
                 i, dout, vld_out, frame_done);
      end
    end
    rst    = 1'b0;
    vld_in = 1'b0;
    @(posedge clk); #1;

    // Ramp frame: pooled maxima 80,112,208,240 >> 4.
    base = n_out;
    push_frame(8'd5, 8'd7, 8'd13, 8'd15);
    send_ramp(0);
    drain();
    check_count("ramp_count", n_out - base, 4);

    // Negative input clamps to 0, large positive saturates to 255.
    push_frame(8'd0, 8'd0, 8'd0, 8'd0);
    send_const(16'hFF9C);
    drain();
    push_frame(8'd255, 8'd255, 8'd255, 8'd255);
    send_const(16'h7FFF);
    drain();

    // 24/16 = 1.5: truncation gives 1, round-half-up gives 2.
`ifdef MAXPOOL_ROUND_EN
    rnd_exp = 8'd2;
`else
    rnd_exp = 8'd1;
`endif
    push_frame(rnd_exp, rnd_exp, rnd_exp, rnd_exp);
    send_const(16'd24);
    drain();

    // Valid every third cycle must not change the result.
    base = n_out;
    push_frame(8'd5, 8'd7, 8'd13, 8'd15);
    send_ramp(2);
    drain();
    check_count("gap_count", n_out - base, 4);

    // Mid-frame reset: sample k=5 completes the first window before the reset.
    push(8'd5, 1'b0);
    for (int k = 0; k < 6; k++) send(16'(16 * k), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    base = n_out;
    push_frame(8'd5, 8'd7, 8'd13, 8'd15);
    send_ramp(0);
    drain();
    check_count("post_reset_count", n_out - base, 4);

    // Two frames back to back.
    base = n_out;
    push_frame(8'd5, 8'd7, 8'd13, 8'd15);
    push_frame(8'd5, 8'd7, 8'd13, 8'd15);
    send_ramp(0);
    send_ramp(0);
    drain();
    check_count("b2b_count", n_out - base, 8);

    check_count("leftover_expected", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
